nios_core_sw_ctrl: RTL
======================

Name: nios_core_sw_ctrl

Overview:
- Avalon-MM slave controller for the 16-bit slide-switch input port on the NIOS_core bus.
- Synchronizes and debounces `in_port` and detects edges into a sticky capture register.
- Drives a maskable interrupt to the NIOS II and schedules when switch states are accepted, using a shared sample-tick prescaler.
- Replaces a plain read-only PIO where the CPU needs clean, interrupt-driven switch events.

Parameters:
- WIDTH, 16, number of switch inputs (1..32).
- TICK_DIV, 50000, clk cycles between debounce samples (1 ms at 50 MHz); minimum 1.
- STABLE_N, 3, consecutive agreeing samples required to accept a new level (2..8).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- chipselect  in  1  Avalon slave select.
- address  in  2  register index.
- write  in  1  write strobe; qualified by chipselect.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous switch inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt to the CPU.

Behaviour:
- Register map, read side, 0-extended to 32 bits:
  - addr 0 DATA: debounced state, read-only.
  - addr 1 IRQMASK: read/write.
  - addr 2 RAW: 2-flop synchronized input, read-only.
  - addr 3 EDGECAP: read, write-1-to-clear.
- readdata: registered every clk from the address mux regardless of `read`, so read latency is 1 cycle. Bits above WIDTH always read 0.
- Synchronizer: 2 flops per bit, giving `sync`. RAW = `sync`.
- Prescaler: counter 0..TICK_DIV-1, wraps to 0 and asserts `tick` for 1 cycle when it equals TICK_DIV-1. With TICK_DIV=1, `tick` is high every cycle.
- Per-bit debounce, evaluated only on `tick`:
  - Shift `sync` bit into a STABLE_N-deep history.
  - If all STABLE_N entries equal and differ from the DATA bit, the DATA bit takes that value on the same cycle.
  - A bit toggling faster than STABLE_N ticks never changes DATA.
- Edge detect: `rise[i]` = DATA[i] transitions 0->1 in the cycle the update occurs.
- EDGECAP:
  - Bit sets on an edge event and holds until cleared.
  - A write to addr 3 with writedata[i]=1 clears bit i.
  - Simultaneous clear and new event on the same bit: the event wins and the bit stays 1.
- IRQMASK: written from writedata[WIDTH-1:0] when chipselect & write & address==1.
- irq: registered, = |(EDGECAP & IRQMASK). It follows EDGECAP/IRQMASK changes 1 cycle later.
- Writes to addr 0 and addr 2 are ignored.
- Writes without chipselect are ignored.
- Reset values:
  - readdata=0, irq=0, DATA=0, EDGECAP=0, IRQMASK=0.
  - Prescaler=0, synchronizer flops=0, history=all 0.
  - With switches already high at reset release, DATA rises after STABLE_N ticks and that generates a rising event (intended: startup report).
- Reset asserted mid-debounce or mid-prescale discards all progress; no event is produced from pre-reset history.

Optional Feature:
- Macro SW_CTRL_BOTH_EDGES_EN.
- Defined: edge event = any DATA transition (0->1 or 1->0).
- Undefined: rising transitions only; falling transitions update DATA but never set EDGECAP.
- Register map and timing are identical in both builds.

Test Plan:
- Reset with in_port=16'h0000, TICK_DIV=4, STABLE_N=3 -> readdata=0, irq=0 on all four addresses; prescaler `tick` every 4th cycle.
- in_port bit0 0->1 held -> RAW bit0 set 2 cycles later; DATA=0x0001 after the 3rd agreeing tick; EDGECAP=0x0001; irq stays 0 while IRQMASK=0.
- Write IRQMASK=0x0001, then write EDGECAP=0x0001 -> irq rises 1 cycle after the mask write and falls 1 cycle after the clear write; EDGECAP reads 0.
- Toggle bit3 every tick for 10 ticks -> DATA bit3 and EDGECAP bit3 never change.
- Clear EDGECAP bit5 on the same cycle bit5's rising update occurs -> EDGECAP bit5 reads 1.
- Release bit0 (1->0) -> without the macro, EDGECAP unchanged and DATA=0; with SW_CTRL_BOTH_EDGES_EN, EDGECAP bit0=1.

Source files
------------

// File: rtl/nios_core_sw_ctrl.sv
// nios_core_sw_ctrl
//   Avalon-MM slave for the slide-switch input port. Raw switch inputs are
//   synchronized, debounced on a shared sample tick, and accepted level
//   changes are captured as sticky edge events that can raise a maskable
//   level interrupt.
//
//   Register map (reads zero-extended to 32 bits, 1-cycle read latency):
//     0 DATA    debounced switch state            (RO)
//     1 IRQMASK interrupt enable per bit          (RW)
//     2 RAW     2-flop synchronized input         (RO)
//     3 EDGECAP sticky edge capture               (R, write-1-to-clear)
//
//   Ports:
//     clk         system clock, rising edge
//     reset       synchronous active-high reset
//     chipselect  Avalon slave select
//     address     register index
//     write       write strobe, qualified by chipselect
//     writedata   write data
//     in_port     raw asynchronous switch inputs
//     readdata    registered read data
//     irq         level interrupt, |(EDGECAP & IRQMASK), registered
//
//   Build option:
//     SW_CTRL_BOTH_EDGES_EN  when defined, falling DATA transitions also set
//                            EDGECAP; otherwise only rising transitions do.
module nios_core_sw_ctrl #(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 50000,
  parameter int STABLE_N = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0]    cnt;
  logic             tick;
  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync;
  // Only STABLE_N-1 past samples are stored; the current sync value is the
  // newest entry of the window, so DATA can update on the tick itself.
  logic [WIDTH-1:0] hist [STABLE_N-1];
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] all_one;
  logic [WIDTH-1:0] all_zero;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wd;

  assign unused_wd = ^writedata;
  assign wr_en     = chipselect & write;

  // Sample-tick prescaler
  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Two-flop synchronizer
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync   <= '0;
    end else begin
      sync_a <= in_port;
      sync   <= sync_a;
    end
  end

  // Debounce window: sync plus stored history must all agree
  always_comb begin
    all_one  = sync;
    all_zero = ~sync;
    for (int k = 0; k < STABLE_N - 1; k++) begin
      all_one  = all_one & hist[k];
      all_zero = all_zero & ~hist[k];
    end
    data_next = data;
    if (tick) data_next = (data & ~all_zero) | all_one;
  end

`ifdef SW_CTRL_BOTH_EDGES_EN
  assign edge_evt = data_next ^ data;
`else
  assign edge_evt = data_next & ~data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STABLE_N - 1; k++) hist[k] <= '0;
      data <= '0;
    end else begin
      if (tick) begin
        hist[0] <= sync;
        for (int k = 1; k < STABLE_N - 1; k++) hist[k] <= hist[k-1];
      end
      data <= data_next;
    end
  end

  // Edge capture: a new event outranks a simultaneous clear
  assign clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      edgecap <= '0;
      irqmask <= '0;
      irq     <= 1'b0;
    end else begin
      edgecap <= (edgecap & ~clr) | edge_evt;
      if (wr_en && address == 2'd1) irqmask <= writedata[WIDTH-1:0];
      irq <= |(edgecap & irqmask);
    end
  end

  // Read data is registered every cycle regardless of a read strobe
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = 32'(data);
      2'd1:    rd_mux = 32'(irqmask);
      2'd2:    rd_mux = 32'(sync);
      default: rd_mux = 32'(edgecap);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

endmodule
